// File: rtl/stdp_pkg.sv
// Shared constants and saturating arithmetic helpers for the STDP core.
package stdp_pkg;

    localparam int N_SYN_D       = 4;
    localparam int W_W_D         = 8;
    localparam int V_W_D         = 12;
    localparam int TR_W_D        = 8;
    localparam int THRESHOLD_D   = 200;
    localparam int LEAK_SHIFT_D  = 3;
    localparam int DECAY_SHIFT_D = 2;
    localparam int A_POS_SHIFT_D = 4;
    localparam int A_NEG_SHIFT_D = 5;
    localparam int REFRAC_D      = 3;
    localparam int W_INIT_D      = 64;

    function automatic int sat_add(input int a, input int b, input int hi);
        int s;
        s = a + b;
        return (s > hi) ? hi : s;
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/stdp_trace.sv
// Single exponential-style trace: loads full scale on a spike and
// decays by a shifted fraction (at least one) each cycle otherwise.
module stdp_trace
    import stdp_pkg::*;
#(
    parameter int TR_W        = TR_W_D,
    parameter int DECAY_SHIFT = DECAY_SHIFT_D
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            spike,
    output logic [TR_W-1:0] trace
);

    logic [TR_W-1:0] trace_q;
    logic [TR_W-1:0] trace_d;
    logic [TR_W-1:0] dec;

    always_comb begin
        dec = trace_q >> DECAY_SHIFT;
        // Minimum step of one keeps small traces from sticking.
        if (dec == '0) dec = TR_W'(1);
        trace_d = trace_q;
        if (spike) begin
            trace_d = '1;
        end else if (trace_q != '0) begin
            trace_d = trace_q - dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trace_q <= '0;
        end else begin
            trace_q <= trace_d;
        end
    end

    assign trace = trace_q;

endmodule

// File: rtl/stdp_synapse_array.sv
// Leaky integrate-and-fire neuron fed by N_SYN plastic synapses with
// trace-based STDP, refractory period and a weight load/readout port.
module stdp_synapse_array
    import stdp_pkg::*;
#(
    parameter int N_SYN       = N_SYN_D,
    parameter int W_W         = W_W_D,
    parameter int V_W         = V_W_D,
    parameter int TR_W        = TR_W_D,
    parameter int THRESHOLD   = THRESHOLD_D,
    parameter int LEAK_SHIFT  = LEAK_SHIFT_D,
    parameter int DECAY_SHIFT = DECAY_SHIFT_D,
    parameter int A_POS_SHIFT = A_POS_SHIFT_D,
    parameter int A_NEG_SHIFT = A_NEG_SHIFT_D,
    parameter int REFRAC      = REFRAC_D,
    parameter int W_INIT      = W_INIT_D,
    localparam int AW = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SYN-1:0] pre_spike,
    input  logic             learn_en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W_W-1:0]   wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [W_W-1:0]   rd_data,
    output logic             post_spike,
    output logic [V_W-1:0]   membrane,
    output logic [TR_W-1:0]  post_trace
);

    localparam int IW    = W_W + AW;
    localparam int CW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int W_MAX = (1 << W_W) - 1;
    localparam int V_MAX = (1 << V_W) - 1;

    logic [W_W-1:0]  w_q [N_SYN];
    logic [W_W-1:0]  w_d [N_SYN];
    logic [V_W-1:0]  v_q;
    logic [V_W-1:0]  v_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            spike_q;
    logic            spike_d;

    logic [TR_W-1:0] pre_tr [N_SYN];
    logic [TR_W-1:0] post_tr;
    logic [IW-1:0]   cur;
    logic            fire;
    int              v_next;
    int              ltp [N_SYN];
    int              ltd [N_SYN];

    for (genvar g = 0; g < N_SYN; g++) begin : g_pre
        stdp_trace #(
            .TR_W        (TR_W),
            .DECAY_SHIFT (DECAY_SHIFT)
        ) u_pre_trace (
            .clk   (clk),
            .rst_n (rst_n),
            .spike (pre_spike[g]),
            .trace (pre_tr[g])
        );
    end

    stdp_trace #(
        .TR_W        (TR_W),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_post_trace (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (fire),
        .trace (post_tr)
    );

    always_comb begin
        cur = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (pre_spike[i]) cur = cur + IW'(w_q[i]);
        end
    end

    always_comb begin
        v_next = sat_add(int'(v_q) - int'(v_q >> LEAK_SHIFT),
                         int'(cur), V_MAX);
        fire  = 1'b0;
        v_d   = v_q;
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            v_d   = '0;
            cnt_d = cnt_q - 1'b1;
        end else if (v_next >= THRESHOLD) begin
            fire  = 1'b1;
            v_d   = '0;
            cnt_d = CW'(REFRAC);
        end else begin
            v_d = V_W'(v_next);
        end
        spike_d = fire;
    end

    // Learning uses pre-edge traces; a write wins over learning.
    always_comb begin
        for (int i = 0; i < N_SYN; i++) begin
            ltp[i] = 0;
            ltd[i] = 0;
            if (fire) ltp[i] = int'(pre_tr[i] >> A_POS_SHIFT);
            if (pre_spike[i]) ltd[i] = int'(post_tr >> A_NEG_SHIFT);
            w_d[i] = w_q[i];
            if (learn_en) begin
                w_d[i] = W_W'(clamp(int'(w_q[i]) + ltp[i] - ltd[i],
                                    0, W_MAX));
            end
            if (wr_en && (wr_addr == AW'(i))) w_d[i] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SYN; i++) w_q[i] <= W_W'(W_INIT);
            v_q     <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_SYN; i++) w_q[i] <= w_d[i];
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (rd_addr == AW'(i)) rd_data = w_q[i];
        end
    end

    assign post_spike = spike_q;
    assign membrane   = v_q;
    assign post_trace = post_tr;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed vector bench for the STDP synapse array.
module tb_stdp_synapse_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pre_spike;
    logic        learn_en;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        post_spike;
    logic [11:0] membrane;
    logic [7:0]  post_trace;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        rst;
        logic [3:0]  pre;
        logic [1:0]  rd;
        logic        sp;
        logic [11:0] mem;
        logic [7:0]  pt;
        logic [7:0]  rdv;
    } vec_t;

    vec_t tbl [17];

    stdp_synapse_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_spike  (pre_spike),
        .learn_en   (learn_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .post_spike (post_spike),
        .membrane   (membrane),
        .post_trace (post_trace)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] p,
                        input logic le, input logic we,
                        input logic [1:0] wa, input logic [7:0] wd);
        rst_n     = r;
        pre_spike = p;
        learn_en  = le;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input int exp,
                          input string name);
        rd_addr = a;
        #1;
        check(name, int'(rd_data), exp);
    endtask

    task automatic do_reset();
        step(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; pre_spike = '0; learn_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        // rst, pre, rd_addr, spike, membrane, post_trace, rd_data
        tbl[0]  = '{1'b0, 4'h0, 2'd0, 1'b0, 12'd0,   8'd0,   8'd64};
        tbl[1]  = '{1'b0, 4'h0, 2'd1, 1'b0, 12'd0,   8'd0,   8'd64};
        tbl[2]  = '{1'b1, 4'h1, 2'd2, 1'b0, 12'd64,  8'd0,   8'd64};
        tbl[3]  = '{1'b1, 4'h1, 2'd3, 1'b0, 12'd120, 8'd0,   8'd64};
        tbl[4]  = '{1'b1, 4'h1, 2'd0, 1'b0, 12'd169, 8'd0,   8'd64};
        tbl[5]  = '{1'b1, 4'h1, 2'd1, 1'b1, 12'd0,   8'd255, 8'd64};
        tbl[6]  = '{1'b1, 4'h1, 2'd2, 1'b0, 12'd0,   8'd192, 8'd64};
        tbl[7]  = '{1'b1, 4'h1, 2'd3, 1'b0, 12'd0,   8'd144, 8'd64};
        tbl[8]  = '{1'b1, 4'h1, 2'd0, 1'b0, 12'd0,   8'd108, 8'd64};
        tbl[9]  = '{1'b1, 4'h1, 2'd1, 1'b0, 12'd64,  8'd81,  8'd64};
        tbl[10] = '{1'b0, 4'h0, 2'd2, 1'b0, 12'd0,   8'd0,   8'd64};
        tbl[11] = '{1'b1, 4'hF, 2'd3, 1'b1, 12'd0,   8'd255, 8'd64};
        tbl[12] = '{1'b1, 4'hF, 2'd0, 1'b0, 12'd0,   8'd192, 8'd64};
        tbl[13] = '{1'b1, 4'hF, 2'd1, 1'b0, 12'd0,   8'd144, 8'd64};
        tbl[14] = '{1'b1, 4'hF, 2'd2, 1'b0, 12'd0,   8'd108, 8'd64};
        tbl[15] = '{1'b1, 4'hF, 2'd3, 1'b1, 12'd0,   8'd255, 8'd64};
        tbl[16] = '{1'b1, 4'h0, 2'd0, 1'b0, 12'd0,   8'd192, 8'd64};

        for (int i = 0; i < 17; i++) begin
            rd_addr = tbl[i].rd;
            step(tbl[i].rst, tbl[i].pre, 1'b0, 1'b0, 2'd0, 8'd0);
            check($sformatf("vec%0d_spike", i), int'(post_spike),
                  int'(tbl[i].sp));
            check($sformatf("vec%0d_mem", i), int'(membrane),
                  int'(tbl[i].mem));
            check($sformatf("vec%0d_ptrace", i), int'(post_trace),
                  int'(tbl[i].pt));
            check($sformatf("vec%0d_rd", i), int'(rd_data),
                  int'(tbl[i].rdv));
        end

        // LTP then LTD around one fire
        do_reset();
        step(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd255);
        rd_chk(2'd0, 255, "ltp_wr_w0");
        step(1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 8'd0);
        check("ltp_mem", int'(membrane), 64);
        step(1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd0);
        check("ltp_fire", int'(post_spike), 1);
        check("ltp_ptrace", int'(post_trace), 255);
        rd_chk(2'd1, 79, "ltp_w1");
        rd_chk(2'd0, 255, "ltp_w0");
        step(1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 8'd0);
        check("ltd_nofire", int'(post_spike), 0);
        check("ltd_ptrace192", int'(post_trace), 192);
        rd_chk(2'd2, 57, "ltd_w2");
        step(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        check("ltd_ptrace144", int'(post_trace), 144);
        step(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        check("ltd_ptrace108", int'(post_trace), 108);

        // LTP saturation at W_MAX
        do_reset();
        step(1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 8'd250);
        step(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd255);
        step(1'b1, 4'b1000, 1'b1, 1'b0, 2'd0, 8'd0);
        check("sat_fire1", int'(post_spike), 1);
        rd_chk(2'd3, 250, "sat_w3_pre");
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0);
        step(1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd0);
        check("sat_fire2", int'(post_spike), 1);
        rd_chk(2'd3, 255, "sat_w3_clamp");
        rd_chk(2'd0, 252, "sat_w0_ltd");

        // LTD floor at zero
        do_reset();
        step(1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 8'd3);
        step(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd255);
        step(1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd0);
        check("floor_fire", int'(post_spike), 1);
        step(1'b1, 4'b1000, 1'b1, 1'b0, 2'd0, 8'd0);
        rd_chk(2'd3, 0, "floor_w3");

        // Write beats learning, then reset mid-refractory
        do_reset();
        step(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd255);
        step(1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 8'd0);
        step(1'b1, 4'b0001, 1'b1, 1'b1, 2'd1, 8'd100);
        check("prio_fire", int'(post_spike), 1);
        rd_chk(2'd1, 100, "prio_w1");
        rd_chk(2'd0, 255, "prio_w0");
        step(1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 8'd9);
        check("rst_spike", int'(post_spike), 0);
        check("rst_mem", int'(membrane), 0);
        check("rst_ptrace", int'(post_trace), 0);
        rd_chk(2'd1, 64, "rst_w1");
        rd_chk(2'd2, 64, "rst_w2");
        step(1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd0);
        check("rst_resume_mem", int'(membrane), 64);
        check("rst_resume_spike", int'(post_spike), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
